// File: rtl/licznik_timer.sv
// Programmable 16-bit timer/counter. It counts prescaled clock ticks up to TOP,
// then raises a sticky match flag and an optional one-cycle interrupt request.
`timescale 1ns/1ps
module licznik_timer #(
  parameter int L_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         licznik_wartosc,
  input  logic               zapisz_L,
  input  logic               zapisz_H,
  input  logic               zapisz_control,
  input  logic               flaga_clear,
  output logic               flaga_licznik,
  output logic               licznik_irq,
  output logic [L_WIDTH-1:0] licznik_stan
);

  // state    | meaning
  // ST_IDLE  | EN=0, counter and prescaler hold
  // ST_RUN   | EN=1, prescaler advances, counter steps on each tick
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [1:0]         ps_sel_q, ps_sel_d;
  logic               ar_q, ar_d;
  logic               ie_q, ie_d;
  logic [L_WIDTH-1:0] top_q, top_d;
  logic [L_WIDTH-1:0] cnt_q, cnt_d;
  logic [5:0]         ps_q, ps_d;
  logic               flag_q, flag_d;
  logic               irq_q, irq_d;
  logic [5:0]         ps_max;
  logic               tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ps_sel_q <= 2'b00;
      ar_q     <= 1'b0;
      ie_q     <= 1'b0;
      top_q    <= '0;
      cnt_q    <= '0;
      ps_q     <= 6'd0;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ps_sel_q <= ps_sel_d;
      ar_q     <= ar_d;
      ie_q     <= ie_d;
      top_q    <= top_d;
      cnt_q    <= cnt_d;
      ps_q     <= ps_d;
      flag_q   <= flag_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    case (ps_sel_q)
      2'b00:   ps_max = 6'd0;
      2'b01:   ps_max = 6'd3;
      2'b10:   ps_max = 6'd15;
      default: ps_max = 6'd63;
    endcase
  end

  assign tick = (state_q == ST_RUN) && (ps_q == ps_max);

  always_comb begin
    state_d  = state_q;
    ps_sel_d = ps_sel_q;
    ar_d     = ar_q;
    ie_d     = ie_q;
    top_d    = top_q;
    cnt_d    = cnt_q;
    ps_d     = ps_q;
    flag_d   = flag_q;
    irq_d    = 1'b0;

    if (zapisz_L) top_d[7:0] = licznik_wartosc;
    if (zapisz_H) top_d[L_WIDTH-1:8] = licznik_wartosc;
    if (flaga_clear) flag_d = 1'b0;

    // A CTRL write restarts timing and swallows any tick landing on the same edge.
    // The match compare below uses top_q, so a same-edge TOP write is not yet seen.
    if (zapisz_control) begin
      state_d  = licznik_wartosc[0] ? ST_RUN : ST_IDLE;
      ps_sel_d = licznik_wartosc[2:1];
      ar_d     = licznik_wartosc[3];
      ie_d     = licznik_wartosc[4];
      cnt_d    = '0;
      ps_d     = 6'd0;
    end else if (tick) begin
      ps_d = 6'd0;
      if (cnt_q == top_q) begin
        cnt_d  = '0;
        flag_d = 1'b1;
        irq_d  = ie_q;
        if (!ar_q) state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (state_q == ST_RUN) begin
      ps_d = ps_q + 6'd1;
    end
  end

  assign flaga_licznik = flag_q;
  assign licznik_irq   = irq_q;
  assign licznik_stan  = cnt_q;

endmodule

// File: tb/tb_licznik_timer.sv
// Directed bench for licznik_timer: expected values are hand-computed from the
// edge numbering of each CTRL write.
`timescale 1ns/1ps
module tb_licznik_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  licznik_wartosc;
  logic        zapisz_L, zapisz_H, zapisz_control, flaga_clear;
  logic        flaga_licznik, licznik_irq;
  logic [15:0] licznik_stan;

  int checks = 0;
  int failures = 0;

  licznik_timer #(.L_WIDTH(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .licznik_wartosc (licznik_wartosc),
    .zapisz_L        (zapisz_L),
    .zapisz_H        (zapisz_H),
    .zapisz_control  (zapisz_control),
    .flaga_clear     (flaga_clear),
    .flaga_licznik   (flaga_licznik),
    .licznik_irq     (licznik_irq),
    .licznik_stan    (licznik_stan)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_l(input logic [7:0] v);
    licznik_wartosc = v; zapisz_L = 1'b1; edges(1); zapisz_L = 1'b0;
  endtask

  task automatic wr_h(input logic [7:0] v);
    licznik_wartosc = v; zapisz_H = 1'b1; edges(1); zapisz_H = 1'b0;
  endtask

  task automatic wr_c(input logic [7:0] v);
    licznik_wartosc = v; zapisz_control = 1'b1; edges(1); zapisz_control = 1'b0;
  endtask

  task automatic clr_flag();
    flaga_clear = 1'b1; edges(1); flaga_clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    licznik_wartosc = 8'h00;
    zapisz_L = 1'b0; zapisz_H = 1'b0; zapisz_control = 1'b0; flaga_clear = 1'b0;
    #3;
    chk("rst_flag", flaga_licznik, 0);
    chk("rst_irq", licznik_irq, 0);
    chk("rst_stan", licznik_stan, 0);
    #10 rst_n = 1'b1;
    edges(2);
    chk("post_rst_stan", licznik_stan, 0);

    // Basic one-shot match, TOP=3, D=1, IE=1
    wr_l(8'h03); wr_h(8'h00); wr_c(8'h11);
    chk("b_stan_k", licznik_stan, 0);
    edges(3);
    chk("b_stan_k3", licznik_stan, 3);
    chk("b_flag_k3", flaga_licznik, 0);
    chk("b_irq_k3", licznik_irq, 0);
    edges(1);
    chk("b_flag_k4", flaga_licznik, 1);
    chk("b_irq_k4", licznik_irq, 1);
    chk("b_stan_k4", licznik_stan, 0);
    edges(1);
    chk("b_irq_k5", licznik_irq, 0);
    edges(5);
    chk("b_stan_idle", licznik_stan, 0);
    chk("b_flag_sticky", flaga_licznik, 1);
    chk("b_irq_idle", licznik_irq, 0);
    clr_flag();
    chk("b_flag_clr", flaga_licznik, 0);

    // Auto-reload, D=4, TOP=2, IE=0: matches at edges 12, 24, 36, ...
    wr_l(8'h02); wr_c(8'h0B);
    edges(11);
    chk("ar_flag_11", flaga_licznik, 0);
    chk("ar_stan_11", licznik_stan, 2);
    edges(1);
    chk("ar_flag_12", flaga_licznik, 1);
    chk("ar_irq_12", licznik_irq, 0);
    chk("ar_stan_12", licznik_stan, 0);
    edges(1);
    clr_flag();
    chk("ar_flag_14", flaga_licznik, 0);
    edges(9);
    chk("ar_flag_23", flaga_licznik, 0);
    edges(1);
    chk("ar_flag_24", flaga_licznik, 1);
    chk("ar_irq_24", licznik_irq, 0);

    // Set/clear collision on the match at edge 36
    clr_flag();
    chk("col_flag_25", flaga_licznik, 0);
    edges(10);
    chk("col_flag_35", flaga_licznik, 0);
    clr_flag();
    chk("col_set_wins", flaga_licznik, 1);

    // CTRL write on the match edge 48 discards the match
    clr_flag();
    edges(10);
    chk("cw_stan_47", licznik_stan, 2);
    wr_c(8'h01);
    chk("cw_flag_48", flaga_licznik, 0);
    chk("cw_stan_48", licznik_stan, 0);
    edges(2);
    chk("cw_flag_50", flaga_licznik, 0);
    chk("cw_stan_50", licznik_stan, 2);
    edges(1);
    chk("cw_flag_51", flaga_licznik, 1);
    chk("cw_stan_51", licznik_stan, 0);

    // 16-bit TOP=0x100, D=1, AR, IE=0
    clr_flag();
    wr_l(8'h00); wr_h(8'h01); wr_c(8'h09);
    edges(255);
    chk("w_stan_ff", licznik_stan, 16'h00FF);
    edges(1);
    chk("w_stan_100", licznik_stan, 16'h0100);
    chk("w_flag_256", flaga_licznik, 0);
    edges(1);
    chk("w_stan_257", licznik_stan, 0);
    chk("w_flag_257", flaga_licznik, 1);
    clr_flag();
    edges(16'h4F);
    chk("w_stan_50", licznik_stan, 16'h0050);
    wr_l(8'h05); wr_h(8'h00);
    chk("w_stan_52", licznik_stan, 16'h0052);
    edges(65453);
    chk("w_stan_ffff", licznik_stan, 16'hFFFF);
    chk("w_no_early", flaga_licznik, 0);
    edges(1);
    chk("w_stan_wrap", licznik_stan, 0);
    chk("w_flag_wrap", flaga_licznik, 0);
    edges(5);
    chk("w_stan_5", licznik_stan, 5);
    chk("w_flag_5", flaga_licznik, 0);
    edges(1);
    chk("w_match_5", flaga_licznik, 1);
    chk("w_stan_m", licznik_stan, 0);

    // Async reset mid-count with flag set
    wr_h(8'h01);
    edges(16'h32);
    chk("r_stan_33", licznik_stan, 16'h0033);
    chk("r_flag_pre", flaga_licznik, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_flag_async", flaga_licznik, 0);
    chk("r_stan_async", licznik_stan, 0);
    chk("r_irq_async", licznik_irq, 0);
    #1 rst_n = 1'b1;
    edges(3);
    chk("r_stan_idle", licznik_stan, 0);
    chk("r_flag_idle", flaga_licznik, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
